av_audio_out: RTL and testbench

- Audio output stage directly downstream of av_machine's 2-bit audio_o. Bit 0 is the digital waveform; bit 1 is volume, where 0 = high and 1 = low.
- Decimates the 1-bit waveform by box-filter averaging over a fixed sample window, then scales by the selected volume amplitude and smooths with a one-pole low-pass.
- Emits signed 16-bit PCM with a valid strobe. The top level feeds it to AUDIO_L/AUDIO_R with AUDIO_S = 1.

---
 rtl/av_audio_pkg.sv | 23 ++
 rtl/av_audio_lpf.sv | 46 ++++
 rtl/av_audio_out.sv | 85 ++++++++
 tb/tb_av_audio_out.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/av_audio_pkg.sv
// av_audio_pkg: shared constants, accumulator type and saturation helper
// for the audio output path (and the LED persistence filter that reuses
// the same low-pass).
package av_audio_pkg;

  localparam int                 WIN_LOG2_DEF = 8;
  localparam int                 LPF_K_DEF    = 3;
  localparam logic signed [15:0] AMP_HI_DEF   = 16'sd12000;
  localparam logic signed [15:0] AMP_LO_DEF   = 16'sd3000;

  // Filter state: 16 integer bits, 8 fraction bits.
  typedef logic signed [23:0] acc_t;

  // Integer part of the accumulator, clamped to the 16-bit PCM range.
  function automatic logic signed [15:0] sat16(input acc_t a);
    acc_t v;
    v = a >>> 8;
    if (v > 24'sd32767)       return 16'sd32767;
    else if (v < -24'sd32768) return -16'sd32768;
    else                      return 16'(v);
  endfunction

endpackage

// File: rtl/av_audio_lpf.sv
// av_audio_lpf: one-pole low-pass y += (x - y) * 2^-LPF_K followed by a
// saturating output register.
//   clk, reset_n : clock, async active-low reset
//   x, x_vld     : signed 16-bit input and its one-cycle strobe
//   y, y_vld     : filtered, saturated output (held) and its strobe,
//                  two clocks after x_vld
module av_audio_lpf
  import av_audio_pkg::*;
#(
  parameter int LPF_K = LPF_K_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] x,
  input  logic               x_vld,
  output logic signed [15:0] y,
  output logic               y_vld
);

  acc_t               y_acc;
  logic               acc_vld;
  logic signed [24:0] diff;
  logic signed [24:0] step;

  // 25-bit difference cannot overflow; the arithmetic shift floors, so a
  // decaying state still walks all the way down to zero.
  always_comb begin
    diff = 25'($signed({x, 8'b0})) - 25'(y_acc);
    step = diff >>> LPF_K;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_acc   <= '0;
      acc_vld <= 1'b0;
      y       <= '0;
      y_vld   <= 1'b0;
    end else begin
      if (x_vld) y_acc <= y_acc + 24'(step);
      acc_vld <= x_vld;
      if (acc_vld) y <= sat16(y_acc);
      y_vld <= acc_vld;
    end
  end

endmodule

// File: rtl/av_audio_out.sv
// av_audio_out: 1-bit audio waveform to signed 16-bit PCM.
// Box-filter decimation over 2^WIN_LOG2 clocks, volume scaling, one-pole LPF.
//   clk_11m_i    : system clock
//   reset_n_i    : async active-low reset
//   audio_i      : [0] waveform, [1] volume (0 = high, 1 = low)
//   mute_i       : forces the filter input to zero (sampled at window end)
//   sample_o     : signed PCM sample, held between strobes
//   sample_vld_o : one-cycle strobe when sample_o updates
module av_audio_out
  import av_audio_pkg::*;
#(
  parameter int                 WIN_LOG2 = WIN_LOG2_DEF,
  parameter int                 LPF_K    = LPF_K_DEF,
  parameter logic signed [15:0] AMP_HI   = AMP_HI_DEF,
  parameter logic signed [15:0] AMP_LO   = AMP_LO_DEF
) (
  input  logic               clk_11m_i,
  input  logic               reset_n_i,
  input  logic [1:0]         audio_i,
  input  logic               mute_i,
  output logic signed [15:0] sample_o,
  output logic               sample_vld_o
);

  localparam int W = WIN_LOG2;

  logic [W-1:0]        win_cnt;
  logic [W:0]          hi_cnt;
  logic [W:0]          cap_cnt;
  logic                cap_vol;
  logic                cap_mute;
  logic [1:0]          vld_pipe;   // [0]: window captured, [1]: x ready
  logic                eow;
  logic signed [W+1:0] d;
  logic signed [15:0]  amp;
  logic signed [W+17:0] prod;
  logic signed [15:0]  x_nxt;
  logic signed [15:0]  x;

  assign eow = &win_cnt;

  // d = 2*cap_cnt - 2^W. {cap_cnt,0} reads as negative at cap_cnt = 2^W,
  // but the subtraction wraps back to +2^W, which fits W+2 bits.
  always_comb begin
    d     = $signed({cap_cnt, 1'b0}) - $signed({2'b01, {W{1'b0}}});
    amp   = cap_vol ? AMP_LO : AMP_HI;
    prod  = (W+18)'(d) * (W+18)'(amp);
    x_nxt = cap_mute ? 16'sd0 : 16'(prod >>> W);
  end

  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_cnt  <= '0;
      hi_cnt   <= '0;
      cap_cnt  <= '0;
      cap_vol  <= 1'b0;
      cap_mute <= 1'b0;
      vld_pipe <= '0;
      x        <= '0;
    end else begin
      win_cnt  <= win_cnt + W'(1);
      vld_pipe <= {vld_pipe[0], eow};
      if (eow) begin
        // Window end counts its own waveform bit; the next window starts now.
        cap_cnt  <= hi_cnt + (W+1)'(audio_i[0]);
        cap_vol  <= audio_i[1];
        cap_mute <= mute_i;
        hi_cnt   <= '0;
      end else begin
        hi_cnt   <= hi_cnt + (W+1)'(audio_i[0]);
      end
      if (vld_pipe[0]) x <= x_nxt;
    end
  end

  av_audio_lpf #(.LPF_K(LPF_K)) u_lpf (
    .clk     (clk_11m_i),
    .reset_n (reset_n_i),
    .x       (x),
    .x_vld   (vld_pipe[1]),
    .y       (sample_o),
    .y_vld   (sample_vld_o)
  );

endmodule

// File: tb/tb_av_audio_out.sv
module tb_av_audio_out;

  logic               clk_11m_i = 1'b0;
  logic               reset_n_i;
  logic [1:0]         audio_i;
  logic               mute_i;
  logic signed [15:0] sample_o;
  logic               sample_vld_o;

  int total = 0;
  int bad   = 0;

  av_audio_out dut (
    .clk_11m_i    (clk_11m_i),
    .reset_n_i    (reset_n_i),
    .audio_i      (audio_i),
    .mute_i       (mute_i),
    .sample_o     (sample_o),
    .sample_vld_o (sample_vld_o)
  );

  always #5 clk_11m_i = ~clk_11m_i;

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    total++;
    if (got - exp > tol || exp - got > tol) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // Counts rising edges until the strobe is seen (sampled 1 after the edge).
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk_11m_i); #1;
      n++;
    end while (!sample_vld_o && n < 2000);
    if (!sample_vld_o) chk("strobe_timeout", 0, 1, 0);
  endtask

  task automatic do_reset(input logic [1:0] aud);
    @(negedge clk_11m_i);
    reset_n_i = 1'b0;
    audio_i   = aud;
    mute_i    = 1'b0;
    repeat (3) @(negedge clk_11m_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    int n, cur, prev, mono, strobes, last, gaps_ok, zeros_ok;
    reset_n_i = 1'b0;
    audio_i   = 2'b01;
    mute_i    = 1'b0;
    #22;
    chk("rst_sample", int'(sample_o), 0, 0);
    chk("rst_vld", int'(sample_vld_o), 0, 0);

    // Step response at high volume.
    do_reset(2'b01);
    wait_strobe(n);
    chk("first_lat", n, 259, 0);
    chk("first_val", int'(sample_o), 1500, 0);
    @(posedge clk_11m_i); #1;
    chk("vld_pulse", int'(sample_vld_o), 0, 0);
    wait_strobe(n);
    chk("period", n + 1, 256, 0);
    chk("second_val", int'(sample_o), 2812, 0);
    repeat (98) wait_strobe(n);
    chk("settle_hi", int'(sample_o), 12000, 8);

    // Mute from steady state.
    mute_i = 1'b1;
    wait_strobe(n);
    chk("mute_first", int'(sample_o), 10500, 1);
    prev = int'(sample_o);
    mono = 1;
    repeat (148) begin
      wait_strobe(n);
      cur = int'(sample_o);
      if (cur > prev) mono = 0;
      prev = cur;
    end
    chk("mute_mono", mono, 1, 0);
    chk("mute_zero", prev, 0, 0);

    // Low volume, waveform low.
    mute_i  = 1'b0;
    audio_i = 2'b10;
    repeat (100) wait_strobe(n);
    chk("settle_lo", int'(sample_o), -3000, 8);

    // Reset at cycle ~100 of a window.
    audio_i = 2'b01;
    repeat (97) @(posedge clk_11m_i);
    #1 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_sample", int'(sample_o), 0, 0);
    chk("mid_rst_vld", int'(sample_vld_o), 0, 0);
    repeat (5) @(negedge clk_11m_i);
    reset_n_i = 1'b1;
    wait_strobe(n);
    chk("mid_rst_lat", n, 259, 0);
    chk("mid_rst_val", int'(sample_o), 1500, 0);

    // Volume drops to low 50 cycles into the window.
    do_reset(2'b01);
    repeat (50) @(negedge clk_11m_i);
    audio_i = 2'b11;
    wait_strobe(n);
    chk("vol_lat", n + 50, 259, 0);
    chk("vol_val", int'(sample_o), 375, 0);

    // 50% duty from reset: every window averages to zero.
    do_reset(2'b00);
    strobes  = 0;
    last     = 0;
    gaps_ok  = 1;
    zeros_ok = 1;
    for (int i = 1; i <= 1027; i++) begin
      @(posedge clk_11m_i); #1;
      if (sample_vld_o) begin
        if (strobes == 0 ? (i != 259) : (i - last != 256)) gaps_ok = 0;
        if (sample_o != 16'sd0) zeros_ok = 0;
        strobes++;
        last = i;
      end
      @(negedge clk_11m_i);
      audio_i[0] = ~audio_i[0];
    end
    chk("duty_strobes", strobes, 4, 0);
    chk("duty_gaps", gaps_ok, 1, 0);
    chk("duty_zero", zeros_ok, 1, 0);
    chk("duty_last", int'(sample_o), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
